// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU op codes,
// mux selects and the main FSM state encoding.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Shared with the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                                       op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback steps and stalls memory states on the mem_ready handshake.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal
);

  state_t state, state_next;
  logic   is_store;
  logic   mem_done;
  logic   pcwrite;
  logic   branch;

  // With single-cycle memory the handshake is ignored entirely
  assign mem_done = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // lw/sw choice and the sticky illegal flag are both taken from the opcode seen in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store <= 1'b0;
      illegal  <= 1'b0;
    end else if (state == DECODE) begin
      is_store <= (op == OP_SW);
      if (!op_is_legal(op)) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:   state_next = mem_done ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = is_store ? MEMWR : MEMRD;
      MEMRD:   state_next = mem_done ? MEMWB : MEMRD;
      MEMWB:   state_next = FETCH;
      MEMWR:   state_next = mem_done ? FETCH : MEMWR;
      EXECUTE: state_next = ALUWB;
      ALUWB:   state_next = FETCH;
      BRANCH:  state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      JUMP:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    aluop    = ALUOP_ADD;
    pcsrc    = PCSRC_ALU;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state)
      FETCH: begin
        memread = 1'b1;
        irwrite = mem_done;
        alusrcb = SRCB_FOUR;
        pcwrite = mem_done;
      end
      DECODE:  alusrcb = SRCB_IMM_SH2;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of whole-instruction vectors,
// hand-written reset/stall sequences and randomized instructions against a step model.
module tb_multicycle_control;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    logic [15:0] mr_low;
    int          cycles;
    int          rw;
    int          mw;
    int          pcen;
    int          mtr;
    logic        ill;
  } entry_t;

  typedef struct {
    logic mr;
    ctl_t exp;
    logic set_ill;
  } step_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegal;
  ctl_t       obs;

  int checks = 0;
  int errors = 0;
  step_t steps[$];
  logic model_ill;

  multicycle_control #(.MEM_WAIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal)
  );

  assign obs = {memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, pcen, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [5:0] o, input logic z, input logic mr);
    op = o;
    zero = z;
    mem_ready = mr;
    #1;
  endtask

  task automatic checkOutput(input string name, input ctl_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: control word of each instruction step, written from the step descriptions
  function automatic ctl_t fetchCtl(input logic ready, input logic ill);
    ctl_t c = '0;
    c.memread = 1'b1; c.irwrite = ready; c.alusrcb = 2'b01; c.pcen = ready; c.illegal = ill;
    return c;
  endfunction

  function automatic logic isLegal(input logic [5:0] o);
    return o == 6'h23 || o == 6'h2B || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02;
  endfunction

  task automatic pushStep(input logic mr, input ctl_t c, input logic set_ill);
    step_t s;
    s.mr = mr; s.exp = c; s.set_ill = set_ill;
    steps.push_back(s);
  endtask

  task automatic buildInstr(input logic [5:0] o, input logic z, input int fw, input int dw);
    ctl_t c;
    for (int i = 0; i < fw; i++) pushStep(1'b0, fetchCtl(1'b0, 1'b0), 1'b0);
    pushStep(1'b1, fetchCtl(1'b1, 1'b0), 1'b0);
    c = '0; c.alusrcb = 2'b11;
    pushStep(1'($urandom_range(0, 1)), c, !isLegal(o));
    if (o == 6'h23 || o == 6'h2B) begin
      c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
      pushStep(1'($urandom_range(0, 1)), c, 1'b0);
      c = '0; c.iord = 1'b1;
      if (o == 6'h23) c.memread = 1'b1; else c.memwrite = 1'b1;
      for (int i = 0; i < dw; i++) pushStep(1'b0, c, 1'b0);
      pushStep(1'b1, c, 1'b0);
      if (o == 6'h23) begin
        c = '0; c.memtoreg = 1'b1; c.regwrite = 1'b1;
        pushStep(1'($urandom_range(0, 1)), c, 1'b0);
      end
    end else if (o == 6'h00) begin
      c = '0; c.alusrca = 1'b1; c.aluop = 2'b10;
      pushStep(1'($urandom_range(0, 1)), c, 1'b0);
      c = '0; c.regdst = 1'b1; c.regwrite = 1'b1;
      pushStep(1'($urandom_range(0, 1)), c, 1'b0);
    end else if (o == 6'h04) begin
      c = '0; c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = z;
      pushStep(1'($urandom_range(0, 1)), c, 1'b0);
    end else if (o == 6'h08) begin
      c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
      pushStep(1'($urandom_range(0, 1)), c, 1'b0);
      c = '0; c.regwrite = 1'b1;
      pushStep(1'($urandom_range(0, 1)), c, 1'b0);
    end else if (o == 6'h02) begin
      c = '0; c.pcsrc = 2'b10; c.pcen = 1'b1;
      pushStep(1'($urandom_range(0, 1)), c, 1'b0);
    end
  endtask

  entry_t tbl[11];
  logic [5:0] legal_ops[6];

  initial begin
    int rw, mw, pc, mtr, mwi;
    ctl_t c;

    tbl[0]  = '{"lw",         6'h23, 1'b0, 16'h0000, 5, 1, 0, 1, 1, 1'b0};
    tbl[1]  = '{"sw",         6'h2B, 1'b0, 16'h0000, 4, 0, 1, 1, 0, 1'b0};
    tbl[2]  = '{"rtype",      6'h00, 1'b1, 16'h0000, 4, 1, 0, 1, 0, 1'b0};
    tbl[3]  = '{"beq_taken",  6'h04, 1'b1, 16'h0000, 3, 0, 0, 2, 0, 1'b0};
    tbl[4]  = '{"beq_not",    6'h04, 1'b0, 16'h0000, 3, 0, 0, 1, 0, 1'b0};
    tbl[5]  = '{"jump",       6'h02, 1'b1, 16'h0000, 3, 0, 0, 2, 0, 1'b0};
    tbl[6]  = '{"addi",       6'h08, 1'b0, 16'h0000, 4, 1, 0, 1, 0, 1'b0};
    tbl[7]  = '{"sw_wait3",   6'h2B, 1'b0, 16'h0038, 7, 0, 4, 1, 0, 1'b0};
    tbl[8]  = '{"lw_fwait2",  6'h23, 1'b0, 16'h0003, 7, 1, 0, 1, 1, 1'b0};
    tbl[9]  = '{"illegal3f",  6'h3F, 1'b1, 16'h0000, 2, 0, 0, 1, 0, 1'b1};
    tbl[10] = '{"addi_after", 6'h08, 1'b0, 16'h0000, 4, 1, 0, 1, 0, 1'b1};
    legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};

    rst_n = 1'b0;
    op = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(6'h00, 1'b0, 1'b1);
    checkOutput("reset_fetch", fetchCtl(1'b1, 1'b0));
    mem_ready = 1'b0;
    rst_n = 1'b1;
    nextCycle();

    // Whole-instruction vectors; each ends by checking the FSM is back in FETCH
    for (int e = 0; e < 11; e++) begin
      rw = 0; mw = 0; pc = 0; mtr = 0; mwi = 0;
      for (int cy = 0; cy < tbl[e].cycles; cy++) begin
        applyStimulus(tbl[e].op, tbl[e].zero, !tbl[e].mr_low[cy]);
        rw  += int'(obs.regwrite);
        mw  += int'(obs.memwrite);
        pc  += int'(obs.pcen);
        mtr += int'(obs.memtoreg);
        mwi += int'(obs.memwrite & obs.iord);
        nextCycle();
      end
      checkValue({tbl[e].name, "_regwrite"}, rw, tbl[e].rw);
      checkValue({tbl[e].name, "_memwrite"}, mw, tbl[e].mw);
      checkValue({tbl[e].name, "_memwrite_iord"}, mwi, tbl[e].mw);
      checkValue({tbl[e].name, "_pcen"}, pc, tbl[e].pcen);
      checkValue({tbl[e].name, "_memtoreg"}, mtr, tbl[e].mtr);
      applyStimulus(tbl[e].op, tbl[e].zero, 1'b0);
      checkOutput({tbl[e].name, "_back_to_fetch"}, fetchCtl(1'b0, tbl[e].ill));
    end

    // Reset asserted while a store is stalled in MEMWR
    applyStimulus(6'h2B, 1'b0, 1'b1); nextCycle();
    applyStimulus(6'h2B, 1'b0, 1'b1); nextCycle();
    applyStimulus(6'h2B, 1'b0, 1'b1); nextCycle();
    applyStimulus(6'h2B, 1'b0, 1'b0);
    c = '0; c.iord = 1'b1; c.memwrite = 1'b1; c.illegal = 1'b1;
    checkOutput("memwr_stall", c);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_drop", fetchCtl(1'b0, 1'b0));
    nextCycle();
    checkOutput("reset_held", fetchCtl(1'b0, 1'b0));
    rst_n = 1'b1;
    applyStimulus(6'h2B, 1'b0, 1'b1);
    checkOutput("reset_release", fetchCtl(1'b1, 1'b0));
    applyStimulus(6'h2B, 1'b0, 1'b0);
    nextCycle();

    // Randomized instructions against the step model
    model_ill = 1'b0;
    for (int n = 0; n < 150; n++) begin
      logic [5:0] o;
      logic z;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel < 6) o = legal_ops[sel];
      else begin
        o = 6'($urandom);
        if (isLegal(o)) o = 6'h3F;
      end
      z = 1'($urandom_range(0, 1));
      steps.delete();
      buildInstr(o, z, $urandom_range(0, 2), $urandom_range(0, 2));
      foreach (steps[i]) begin
        c = steps[i].exp;
        c.illegal = model_ill;
        applyStimulus(o, z, steps[i].mr);
        checkOutput($sformatf("rand_%0d_op%02h_step%0d", n, o, i), c);
        nextCycle();
        if (steps[i].set_ill) model_ill = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
